// File: rtl/viterbi_ber_monitor_if.sv
// ============================================================================
// Module   : viterbi_ber_monitor_if
// Brief    : Symbol/decoded-bit stream and BER status bundle for the monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface viterbi_ber_monitor_if #(
  parameter int CNT_W = 11
);
  logic [1:0]       in_sym;
  logic             dec_bit;
  logic             dec_valid;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic             over_thresh;

  modport master (
    output in_sym, dec_bit, dec_valid, start,
    input  busy, done, err_count, over_thresh
  );

  modport slave (
    input  in_sym, dec_bit, dec_valid, start,
    output busy, done, err_count, over_thresh
  );
endinterface

`default_nettype wire

// File: rtl/viterbi_ber_monitor.sv
// ============================================================================
// Module   : viterbi_ber_monitor
// Brief    : Re-encodes decoded bits (rate 1/2, K=3) and counts channel bit
//            errors against the delayed received symbols over a window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module viterbi_ber_monitor #(
  parameter int       WINDOW = 1024,
  parameter int       CNT_W  = 11,
  parameter int       THRESH = 64,
  parameter bit [2:0] G0     = 3'b111,
  parameter bit [2:0] G1     = 3'b101
) (
  input  wire logic            clock,
  input  wire logic            reset,
  viterbi_ber_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last   = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_enc;
  logic [CNT_W-1:0] r_sym;
  logic [CNT_W-1:0] r_err;
  logic             r_over;

  logic [2:0]       w_v;
  logic             w_c0;
  logic             w_c1;
  logic [1:0]       w_diff;
  logic [1:0]       w_e;
  logic [CNT_W-1:0] w_err_next;
  logic             w_last;

  // Re-encode the decoded bit using the encoder history it was produced under.
  assign w_v        = {bus.dec_bit, r_enc};
  assign w_c0       = ^(w_v & G0);
  assign w_c1       = ^(w_v & G1);
  assign w_diff     = bus.in_sym ^ {w_c0, w_c1};
  assign w_e        = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
  assign w_err_next = r_err + CNT_W'(w_e);
  assign w_last     = (r_sym == c_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_COUNT;
      ST_COUNT: if (bus.dec_valid && w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_enc   <= 2'b00;
      r_sym   <= '0;
      r_err   <= '0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Encoder history follows the decoded stream regardless of window state.
      if (bus.dec_valid) r_enc <= {bus.dec_bit, r_enc[1]};
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_err  <= '0;
            r_sym  <= '0;
            r_over <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (bus.dec_valid) begin
            r_err <= w_err_next;
            r_sym <= r_sym + CNT_W'(1);
            if (w_last) r_over <= (w_err_next >= c_thresh);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state == ST_COUNT);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.err_count   = r_err;
  assign bus.over_thresh = r_over;

endmodule

`default_nettype wire
